// File: rtl/intersection_pkg.sv
// Shared types and defaults for the intersection conflict monitor.
package intersection_pkg;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        MONITOR = 2'd1,
        FAULT   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FK_NONE  = 2'd0,
        FK_SIMUL = 2'd1,
        FK_CLEAR = 2'd2
    } fault_kind_e;

    localparam int CH_PED  = 0;
    localparam int CH_UP   = 1;
    localparam int CH_DOWN = 2;
    localparam int CH_TURN = 3;

    // ped-up, ped-down and turn-down conflict in the default channel map
    localparam logic [15:0] DEFAULT_CONFLICT = 16'h4916;

endpackage

// File: rtl/intersection_monitor_clear_timer.sv
// Per-channel all-red timer: counts cycles since the channel's gated green
// was last high, saturating at CLEAR_CYCLES.
module clear_timer
    import intersection_pkg::*;
#(
    parameter int CLEAR_CYCLES = 4,
    parameter int TW           = $clog2(CLEAR_CYCLES + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          green,
    output logic [TW-1:0] count,
    output logic          cleared
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (green) begin
            count_d = '0;
        end else if (count_q != TW'(CLEAR_CYCLES)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign cleared = (count_q == TW'(CLEAR_CYCLES));

endmodule

// File: rtl/intersection_monitor.sv
// Green gate between the light sequencer and lamp drivers: blocks conflicting
// greens, enforces all-red clearance and latches the first offending pair.
module intersection_monitor
    import intersection_pkg::*;
#(
    parameter int                   N_CH         = 4,
    parameter logic [N_CH*N_CH-1:0] CONFLICT     = DEFAULT_CONFLICT,
    parameter int                   CLEAR_CYCLES = 4,
    localparam int                  IDX_W        = $clog2(N_CH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CH-1:0]  green_in,
    input  logic             fault_clear,
    output logic [N_CH-1:0]  green_out,
    output logic             fault,
    output logic [1:0]       fault_kind,
    output logic [IDX_W-1:0] fault_a,
    output logic [IDX_W-1:0] fault_b,
    output logic [7:0]       fault_count,
    output logic [1:0]       dbg_state
);

    localparam int TW = $clog2(CLEAR_CYCLES + 1);

    function automatic bit conflict_ok();
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (CONFLICT[i*N_CH+i]) ok = 1'b0;
            for (int j = 0; j < N_CH; j++) begin
                if (CONFLICT[i*N_CH+j] != CONFLICT[j*N_CH+i]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    if (!conflict_ok()) begin : g_bad_conflict
        $fatal(1, "intersection_monitor: CONFLICT must be symmetric with zero diagonal");
    end
    if (CLEAR_CYCLES < 1) begin : g_bad_clear
        $fatal(1, "intersection_monitor: CLEAR_CYCLES must be >= 1");
    end

    state_e           state_q,       state_d;
    logic [N_CH-1:0]  green_out_q,   green_out_d;
    logic             fault_q,       fault_d;
    fault_kind_e      fault_kind_q,  fault_kind_d;
    logic [IDX_W-1:0] fault_a_q,     fault_a_d;
    logic [IDX_W-1:0] fault_b_q,     fault_b_d;
    logic [7:0]       fault_count_q, fault_count_d;

    logic [TW-1:0]    timer_count [N_CH];
    logic [N_CH-1:0]  timer_cleared;

    for (genvar i = 0; i < N_CH; i++) begin : g_timer
        clear_timer #(
            .CLEAR_CYCLES (CLEAR_CYCLES),
            .TW           (TW)
        ) u_timer (
            .clock   (clock),
            .reset   (reset),
            .green   (green_out_q[i]),
            .count   (timer_count[i]),
            .cleared (timer_cleared[i])
        );
    end

    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  busy;
    logic             sim_hit,  clr_hit;
    logic [IDX_W-1:0] sim_a, sim_b, clr_a, clr_b;

    // Ascending pair scan: the first hit of each kind is the lowest (a,b).
    always_comb begin
        rise    = green_in & ~green_out_q;
        busy    = '0;
        sim_hit = 1'b0;
        clr_hit = 1'b0;
        sim_a   = '0;
        sim_b   = '0;
        clr_a   = '0;
        clr_b   = '0;
        for (int i = 0; i < N_CH; i++) begin
            busy[i] = green_out_q[i] | (timer_count[i] < TW'(CLEAR_CYCLES));
        end
        for (int a = 0; a < N_CH; a++) begin
            for (int b = a + 1; b < N_CH; b++) begin
                if (!sim_hit && CONFLICT[a*N_CH+b] && green_in[a] && green_in[b]) begin
                    sim_hit = 1'b1;
                    sim_a   = IDX_W'(a);
                    sim_b   = IDX_W'(b);
                end
                if (!clr_hit && CONFLICT[a*N_CH+b] &&
                    ((rise[b] && busy[a]) || (rise[a] && busy[b]))) begin
                    clr_hit = 1'b1;
                    clr_a   = IDX_W'(a);
                    clr_b   = IDX_W'(b);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        green_out_d   = '0;
        fault_d       = fault_q;
        fault_kind_d  = fault_kind_q;
        fault_a_d     = fault_a_q;
        fault_b_d     = fault_b_q;
        fault_count_d = fault_count_q;
        unique case (state_q)
            STARTUP: begin
                if (&timer_cleared) state_d = MONITOR;
            end
            MONITOR: begin
                if (sim_hit || clr_hit) begin
                    state_d      = FAULT;
                    fault_d      = 1'b1;
                    fault_kind_d = sim_hit ? FK_SIMUL : FK_CLEAR;
                    fault_a_d    = sim_hit ? sim_a : clr_a;
                    fault_b_d    = sim_hit ? sim_b : clr_b;
                    if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
                end else begin
                    green_out_d = green_in;
                end
            end
            FAULT: begin
                // Leaving FAULT requires the sequencer to be dark as well.
                if (fault_clear && (green_in == '0)) begin
                    state_d      = STARTUP;
                    fault_d      = 1'b0;
                    fault_kind_d = FK_NONE;
                    fault_a_d    = '0;
                    fault_b_d    = '0;
                end
            end
            default: state_d = STARTUP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= STARTUP;
            green_out_q   <= '0;
            fault_q       <= 1'b0;
            fault_kind_q  <= FK_NONE;
            fault_a_q     <= '0;
            fault_b_q     <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            green_out_q   <= green_out_d;
            fault_q       <= fault_d;
            fault_kind_q  <= fault_kind_d;
            fault_a_q     <= fault_a_d;
            fault_b_q     <= fault_b_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign green_out   = green_out_q;
    assign fault       = fault_q;
    assign fault_kind  = fault_kind_q;
    assign fault_a     = fault_a_q;
    assign fault_b     = fault_b_q;
    assign fault_count = fault_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_intersection_monitor.sv
// Bench for intersection_monitor: a default 4-channel instance and a 6-channel
// instance, both checked every cycle against a timestamp-based model.
module tb_intersection_monitor;

    localparam int          C0    = 4;
    localparam int          C1    = 2;
    localparam logic [35:0] CONF1 = 36'h0_4210_8420;  // pairs (0,5) (1,4) (2,3)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] gin_v [2];
    logic       clr_v [2];
    logic       rst_v [2];

    logic [3:0] g_out0;
    logic       f0;
    logic [1:0] fk0, fa0, fb0, st0;
    logic [7:0] fc0;

    logic [5:0] g_out1;
    logic       f1;
    logic [1:0] fk1, st1;
    logic [2:0] fa1, fb1;
    logic [7:0] fc1;

    intersection_monitor #(.CLEAR_CYCLES(C0)) u_dut0 (
        .clock       (clk),
        .reset       (rst_v[0]),
        .green_in    (gin_v[0][3:0]),
        .fault_clear (clr_v[0]),
        .green_out   (g_out0),
        .fault       (f0),
        .fault_kind  (fk0),
        .fault_a     (fa0),
        .fault_b     (fb0),
        .fault_count (fc0),
        .dbg_state   (st0)
    );

    intersection_monitor #(.N_CH(6), .CONFLICT(CONF1), .CLEAR_CYCLES(C1)) u_dut1 (
        .clock       (clk),
        .reset       (rst_v[1]),
        .green_in    (gin_v[1]),
        .fault_clear (clr_v[1]),
        .green_out   (g_out1),
        .fault       (f1),
        .fault_kind  (fk1),
        .fault_a     (fa1),
        .fault_b     (fb1),
        .fault_count (fc1),
        .dbg_state   (st1)
    );

    // Model state: 0 startup, 1 monitor, 2 fault; clearance from timestamps.
    int          n_ch   [2];
    int          clr_c  [2];
    logic [63:0] conf_m [2];
    int          m_state [2];
    logic [5:0]  m_green [2];
    int          m_fault [2];
    int          m_kind  [2];
    int          m_a     [2];
    int          m_b     [2];
    int          m_cnt   [2];
    int          last_on [2][6];
    int          cyc;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input int k);
        int n, cc, vk, va, vb;
        logic [5:0] g, rise, busy;
        bit all_clr;
        n  = n_ch[k];
        cc = clr_c[k];
        if (rst_v[k]) begin
            m_state[k] = 0;
            m_green[k] = '0;
            m_fault[k] = 0;
            m_kind[k]  = 0;
            m_a[k]     = 0;
            m_b[k]     = 0;
            m_cnt[k]   = 0;
            for (int i = 0; i < 6; i++) last_on[k][i] = cyc;
            return;
        end
        g       = gin_v[k] & 6'((1 << n) - 1);
        rise    = g & ~m_green[k];
        busy    = '0;
        all_clr = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (cyc - last_on[k][i] <= cc) all_clr = 1'b0;
            busy[i] = m_green[k][i] || (cyc - last_on[k][i] <= cc);
        end
        vk = 0; va = 0; vb = 0;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (vk == 0 && conf_m[k][a*n+b] && g[a] && g[b]) begin
                    vk = 1; va = a; vb = b;
                end
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (vk == 0 && conf_m[k][a*n+b] &&
                    ((rise[b] && busy[a]) || (rise[a] && busy[b]))) begin
                    vk = 2; va = a; vb = b;
                end
        for (int i = 0; i < n; i++) if (m_green[k][i]) last_on[k][i] = cyc;
        case (m_state[k])
            0: begin
                m_green[k] = '0;
                if (all_clr) m_state[k] = 1;
            end
            1: begin
                if (vk != 0) begin
                    m_green[k] = '0;
                    m_state[k] = 2;
                    m_fault[k] = 1;
                    m_kind[k]  = vk;
                    m_a[k]     = va;
                    m_b[k]     = vb;
                    if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
                end else begin
                    m_green[k] = g;
                end
            end
            default: begin
                m_green[k] = '0;
                if (clr_v[k] && g == '0) begin
                    m_state[k] = 0;
                    m_fault[k] = 0;
                    m_kind[k]  = 0;
                    m_a[k]     = 0;
                    m_b[k]     = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("green0", 32'(g_out0), 32'(m_green[0][3:0]));
        check("fault0", 32'(f0),     32'(m_fault[0]));
        check("kind0",  32'(fk0),    32'(m_kind[0]));
        check("a0",     32'(fa0),    32'(m_a[0]));
        check("b0",     32'(fb0),    32'(m_b[0]));
        check("count0", 32'(fc0),    32'(m_cnt[0]));
        check("state0", 32'(st0),    32'(m_state[0]));
        check("green1", 32'(g_out1), 32'(m_green[1]));
        check("fault1", 32'(f1),     32'(m_fault[1]));
        check("kind1",  32'(fk1),    32'(m_kind[1]));
        check("a1",     32'(fa1),    32'(m_a[1]));
        check("b1",     32'(fb1),    32'(m_b[1]));
        check("count1", 32'(fc1),    32'(m_cnt[1]));
        check("state1", 32'(st1),    32'(m_state[1]));
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        cyc++;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic recover0();
        gin_v[0] = '0;
        clr_v[0] = 1'b0;
        repeat (5) step();
        clr_v[0] = 1'b1;
        step();
        clr_v[0] = 1'b0;
        step();
        check("recover0_state", 32'(st0), 32'd1);
    endtask

    initial begin
        int idx;
        n_ch[0] = 4;  n_ch[1] = 6;
        clr_c[0] = C0; clr_c[1] = C1;
        conf_m[0] = 64'h4916;
        conf_m[1] = 64'(CONF1);
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            gin_v[k] = '0;
            clr_v[k] = 1'b0;
            rst_v[k] = 1'b1;
        end

        // clock/reset
        repeat (2) step();
        check("reset_green0", 32'(g_out0), 32'd0);
        check("reset_count0", 32'(fc0), 32'd0);
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;

        // startup hold-off with up requested
        gin_v[0] = 6'b000010;
        for (int s = 0; s <= C0; s++) begin
            step();
            check("startup_dark", 32'(g_out0), 32'd0);
        end
        step();
        check("first_green", 32'(g_out0), 32'b0010);
        check("first_nofault", 32'(f0), 32'd0);

        // ped+up simultaneously
        step();
        gin_v[0] = 6'b000011;
        step();
        check("simul_green", 32'(g_out0), 32'd0);
        check("simul_fault", 32'(f0), 32'd1);
        check("simul_kind", 32'(fk0), 32'd1);
        check("simul_a", 32'(fa0), 32'd0);
        check("simul_b", 32'(fb0), 32'd1);
        check("simul_count", 32'(fc0), 32'd1);

        // fault_clear ignored while a green is requested, then honoured
        gin_v[0] = '0;
        repeat (4) step();
        gin_v[0] = 6'b000100;
        clr_v[0] = 1'b1;
        step();
        check("clr_ignored_fault", 32'(f0), 32'd1);
        check("clr_ignored_state", 32'(st0), 32'd2);
        gin_v[0] = '0;
        step();
        check("clr_fault", 32'(f0), 32'd0);
        check("clr_kind", 32'(fk0), 32'd0);
        check("clr_state", 32'(st0), 32'd0);
        clr_v[0] = 1'b0;
        step();
        check("startup_one_cycle", 32'(st0), 32'd1);
        check("count_kept", 32'(fc0), 32'd1);

        // clearance: ped requested CLEAR_CYCLES after up went dark -> fault
        gin_v[0] = 6'b000010;
        repeat (2) step();
        gin_v[0] = '0;
        step();
        repeat (C0 - 1) step();
        gin_v[0] = 6'b000001;
        step();
        check("clear_fault", 32'(f0), 32'd1);
        check("clear_kind", 32'(fk0), 32'd2);
        check("clear_a", 32'(fa0), 32'd0);
        check("clear_b", 32'(fb0), 32'd1);
        recover0();

        // one cycle later is accepted
        gin_v[0] = 6'b000010;
        repeat (2) step();
        gin_v[0] = '0;
        step();
        repeat (C0) step();
        gin_v[0] = 6'b000001;
        step();
        check("clear_ok_green", 32'(g_out0), 32'b0001);
        check("clear_ok_fault", 32'(f0), 32'd0);

        // turn -> up handover in one cycle
        gin_v[0] = '0;
        repeat (5) step();
        gin_v[0] = 6'b001000;
        repeat (2) step();
        check("handover_turn", 32'(g_out0), 32'b1000);
        gin_v[0] = 6'b000010;
        step();
        check("handover_up", 32'(g_out0), 32'b0010);
        check("handover_fault", 32'(f0), 32'd0);
        gin_v[0] = '0;

        // six channels: (1,4) beats (2,3)
        gin_v[1] = 6'b011110;
        step();
        check("n6_kind", 32'(fk1), 32'd1);
        check("n6_a", 32'(fa1), 32'd1);
        check("n6_b", 32'(fb1), 32'd4);
        for (int r = 0; r < 255; r++) begin
            gin_v[1] = '0;
            clr_v[1] = 1'b1;
            step();
            clr_v[1] = 1'b0;
            step();
            gin_v[1] = 6'b011110;
            step();
        end
        check("n6_saturate", 32'(fc1), 32'd255);
        check("n6_sat_fault", 32'(f1), 32'd1);

        // reset in the middle of FAULT
        gin_v[1] = '0;
        rst_v[1] = 1'b1;
        step();
        check("midreset_fault", 32'(f1), 32'd0);
        check("midreset_count", 32'(fc1), 32'd0);
        check("midreset_a", 32'(fa1), 32'd0);
        rst_v[1] = 1'b0;

        // randomized traffic on both instances
        for (int s = 0; s < 1500; s++) begin
            for (int k = 0; k < 2; k++) begin
                clr_v[k] = 1'b0;
                rst_v[k] = 1'b0;
                if ($urandom_range(0, 299) == 0) begin
                    rst_v[k] = 1'b1;
                end else if (m_state[k] == 2 && $urandom_range(0, 3) == 0) begin
                    gin_v[k] = '0;
                    clr_v[k] = 1'b1;
                end else begin
                    if ($urandom_range(0, 2) == 0) begin
                        idx = $urandom_range(0, n_ch[k] - 1);
                        gin_v[k][idx] = ~gin_v[k][idx];
                    end
                    if ($urandom_range(0, 19) == 0) clr_v[k] = 1'b1;
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intersection_monitor.md
Name: intersection_monitor

Overview:
Parametrised run-time conflict monitor and green gate for an N-channel intersection controller. It sits between the light-sequencing logic (green_in) and the lamp drivers (green_out). It enforces a configurable conflict matrix and a minimum all-red clearance between conflicting greens, so that green_out never shows a conflicting pair. On any violation it latches a fault, forces all greens off and reports the offending pair.

Parameters:
N_CH, 4, number of signal channels (default map: 0 pedestrian, 1 up, 2 down, 3 turn)
CONFLICT, N_CH*N_CH bits, 16'h4916, bit i*N_CH+j set means channels i and j conflict; default encodes ped-up, ped-down, turn-down; must be symmetric with zero diagonal (elaboration-time check, fatal otherwise)
CLEAR_CYCLES, 4, minimum all-red cycles a conflicting pair must observe; must be >= 1
IDX_W, $clog2(N_CH), channel index width (derived, not overridable)

Ports:
clock  input  1  single clock, all logic on posedge
reset  input  1  synchronous, active-high
green_in  input  N_CH  requested greens from the sequencer
fault_clear  input  1  one-cycle request to leave FAULT
green_out  output  N_CH  gated greens to lamp drivers (registered)
fault  output  1  high while in FAULT
fault_kind  output  2  0 none, 1 simultaneous conflict, 2 clearance violation
fault_a  output  IDX_W  lower index of offending pair
fault_b  output  IDX_W  higher index of offending pair
fault_count  output  8  saturating count of FAULT entries

Behaviour:
- Reset: green_out=0, fault=0, fault_kind=0, fault_a=fault_b=0, fault_count=0, all clearance timers=0, state=STARTUP.
- Per-channel timer t[i] (width holds CLEAR_CYCLES): next t[i] = 0 if green_out[i], else min(t[i]+1, CLEAR_CYCLES).
- Rise of channel j: green_in[j] & ~green_out[j].
- Simultaneous violation (i<j): green_in[i] & green_in[j] & CONFLICT[i][j].
- Clearance violation: rise of j & CONFLICT[i][j] & (green_out[i] | t[i] < CLEAR_CYCLES), for any i.
- Priority: simultaneous over clearance; within a kind, lowest (a,b) lexicographic with a<b.
- FSM:
  - STARTUP: green_out forced 0, violations ignored. Go to MONITOR when every t[i]==CLEAR_CYCLES.
  - MONITOR: if no violation this cycle, green_out <= green_in (1-cycle latency). On a violation, the next cycle has green_out=0, fault=1, kind/a/b loaded, fault_count+1 (saturating at 255), state FAULT. A violating green_in never reaches green_out.
  - FAULT: green_out=0; kind/a/b held. fault_clear with green_in==0 goes to STARTUP and clears fault, kind, a, b the next cycle. fault_clear with green_in!=0 is ignored. A new violation in FAULT is not recorded.
- Timing: with green_out[i] last high at cycle t, a conflicting green_in[j] is first accepted at t+CLEAR_CYCLES+1, and green_out[j] rises at t+CLEAR_CYCLES+2.
- Non-conflicting channels hand over freely in the same cycle.
- reset mid-operation overrides everything, fault_count included. fault_clear never resets fault_count.

Decomposition:
- Package intersection_pkg:
  - state enum {STARTUP, MONITOR, FAULT}
  - fault_kind enum {FK_NONE, FK_SIMUL, FK_CLEAR}
  - default channel index constants CH_PED=0, CH_UP=1, CH_DOWN=2, CH_TURN=3
  - DEFAULT_CONFLICT=16'h4916
- Sub-module clear_timer: one per channel, generated N_CH times; inputs green, clock, reset; outputs saturated count and cleared flag.
- Top holds the violation scan, priority encode, FSM and output registers.

Test Plan:
- Reset then green_in=4'b0010 held: green_out=0 for the first CLEAR_CYCLES+1 cycles (STARTUP), then 4'b0010 the cycle after MONITOR entry; fault stays 0.
- In MONITOR, green_in 4'b0010 then 4'b0011 (ped+up): green_out never 4'b0011; next cycle fault=1, kind=1, a=0, b=1, count=1, green_out=0.
- Up green_out last high at cycle 10, CLEAR_CYCLES=4; ped requested at cycle 14 gives fault kind=2, a=0, b=1. Repeat with the request at cycle 15: no fault, green_out[0]=1 at cycle 16.
- Turn 4'b1000 to up 4'b0010 handover in the same cycle (non-conflicting): green_out goes 4'b1000 then 4'b0010 with no gap and no fault.
- In FAULT, fault_clear with green_in=4'b0100 is ignored. fault_clear with green_in=0 clears fault/kind next cycle, then STARTUP lasts 1 cycle; fault_count stays 1.
- N_CH=6 with a custom CONFLICT, plus simultaneous pairs (1,4) and (2,3): report a=1, b=4. Force 256 faults: fault_count saturates at 255. Reset asserted mid-FAULT: all outputs 0 next cycle.
